aes_key_schedule_ctrl: RTL and testbench

Iterative AES-128 key-schedule controller. On a start request it loads the 128-bit cipher key, then runs the single-round key-expansion datapath once per clock for rounds 1..10, driving its round-number input. Each round key is streamed out with a valid strobe, and optionally retained in an 11-entry key store. It sits between the key-load interface and the round pipeline, which consumes keys by stream or by index.

---
 rtl/aes_key_schedule_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_aes_key_schedule_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_ctrl.sv
// Iterative AES-128 key-schedule controller.
// Loads a cipher key on start, then runs the single-round key-expansion
// datapath once per clock for rounds 1..10. Each round key is streamed out
// with rk_valid, and done pulses with round key 10.
// Optional 11-entry round-key store: define AES_KEYSCHED_STORE_EN.

// Single-round AES-128 key expansion: next round key from the current key
// and the round number (1..10), which selects Rcon.
module aes_key_expand #(
  parameter int LENGTH = 128,
  parameter int DWORD  = 32
) (
  input  logic [LENGTH-1:0] key,
  input  logic [3:0]        rnd,
  output logic [LENGTH-1:0] next_key
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 = x^-1 in GF(2^8), with 0 mapping to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [DWORD-1:0] w0, w1, w2, w3;
  logic [DWORD-1:0] rot_w, sub_w, tmp_w;
  logic [DWORD-1:0] n0, n1, n2, n3;

  // Word recurrence: w'0 = w0 ^ SubWord(RotWord(w3)) ^ Rcon, then chained XORs.
  always_comb begin
    w0    = key[4*DWORD-1 -: DWORD];
    w1    = key[3*DWORD-1 -: DWORD];
    w2    = key[2*DWORD-1 -: DWORD];
    w3    = key[DWORD-1:0];
    rot_w = {w3[DWORD-9:0], w3[DWORD-1 -: 8]};
    sub_w = '0;
    for (int i = 0; i < DWORD / 8; i++) begin
      sub_w[i*8 +: 8] = sbox(rot_w[i*8 +: 8]);
    end
    tmp_w    = sub_w ^ {rcon(rnd), {(DWORD-8){1'b0}}};
    n0       = w0 ^ tmp_w;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

endmodule

module aes_key_schedule_ctrl #(
  parameter int LENGTH  = 128,
  parameter int DWORD   = 32,
  parameter int NROUNDS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LENGTH-1:0] cipher_key,
  output logic              busy,
  output logic              rk_valid,
  output logic [3:0]        rk_idx,
  output logic [LENGTH-1:0] rk,
  output logic              done,
  input  logic [3:0]        rd_idx,
  output logic [LENGTH-1:0] rd_key,
  output logic              keys_ready
);

  localparam logic [3:0] LAST = 4'(NROUNDS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_n;
  logic [LENGTH-1:0] cur_key, key_n;
  logic [3:0]        rnd, rnd_n;
  logic [LENGTH-1:0] exp_key;
  logic              emit;
  logic              emit_done;
  logic [3:0]        emit_idx;
  logic [LENGTH-1:0] emit_key;

  aes_key_expand #(
    .LENGTH (LENGTH),
    .DWORD  (DWORD)
  ) u_expand (
    .key      (cur_key),
    .rnd      (rnd),
    .next_key (exp_key)
  );

  assign busy = (state == RUN);

  // Next-state, next key/round and the key to emit on this edge.
  always_comb begin
    state_n   = state;
    key_n     = cur_key;
    rnd_n     = rnd;
    emit      = 1'b0;
    emit_done = 1'b0;
    emit_idx  = rk_idx;
    emit_key  = rk;
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = RUN;
          key_n    = cipher_key;
          rnd_n    = 4'd1;
          emit     = 1'b1;
          emit_idx = 4'd0;
          emit_key = cipher_key;
        end
      end
      RUN: begin
        if (rnd == 4'd0 || rnd > LAST) begin
          // Unreachable round number: abandon quietly.
          state_n = IDLE;
          rnd_n   = 4'd0;
        end else begin
          key_n    = exp_key;
          emit     = 1'b1;
          emit_idx = rnd;
          emit_key = exp_key;
          if (rnd == LAST) begin
            state_n   = IDLE;
            rnd_n     = 4'd0;
            emit_done = 1'b1;
          end else begin
            rnd_n = rnd + 4'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        rnd_n   = 4'd0;
      end
    endcase
  end

  // State, working key and registered stream outputs; strobes drop when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_key  <= '0;
      rnd      <= 4'd0;
      rk       <= '0;
      rk_idx   <= 4'd0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cur_key  <= key_n;
      rnd      <= rnd_n;
      rk       <= emit_key;
      rk_idx   <= emit_idx;
      rk_valid <= emit;
      done     <= emit_done;
    end
  end

`ifdef AES_KEYSCHED_STORE_EN
  logic [LENGTH-1:0] store [0:NROUNDS];

  // Key store: written alongside each emitted key; registered read port;
  // ready once a full schedule has landed, cleared on the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NROUNDS; i++) store[i] <= '0;
      rd_key     <= '0;
      keys_ready <= 1'b0;
    end else begin
      if (emit) store[emit_idx] <= emit_key;
      rd_key <= (rd_idx <= LAST) ? store[rd_idx] : '0;
      if (state == IDLE && start) keys_ready <= 1'b0;
      else if (emit_done)         keys_ready <= 1'b1;
    end
  end
`else
  // No store: the read port addresses nothing and always returns zero.
  assign rd_key     = {LENGTH{1'b0}} & {LENGTH{^rd_idx}};
  assign keys_ready = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Testbench for aes_key_schedule_ctrl: scoreboard of expected round keys
// from an independent AES-128 key-expansion model, plus spec vectors.
module tb_aes_key_schedule_ctrl;

`ifdef AES_KEYSCHED_STORE_EN
  localparam bit STORE = 1'b1;
`else
  localparam bit STORE = 1'b0;
`endif

  localparam logic [127:0] K_FIPS   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_FIPS = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_FIPS= 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK10_ZERO= 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] cipher_key;
  logic         busy, rk_valid, done, keys_ready;
  logic [3:0]   rk_idx, rd_idx;
  logic [127:0] rk, rd_key;

  aes_key_schedule_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cipher_key (cipher_key),
    .busy       (busy),
    .rk_valid   (rk_valid),
    .rk_idx     (rk_idx),
    .rk         (rk),
    .done       (done),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .keys_ready (keys_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   idx;
    logic         dn;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  bit           mon_en = 1'b0;
  logic [127:0] last_sched [0:10];

  // Reference model: GF arithmetic by brute-force inverse search.
  function automatic logic [7:0] ref_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = ref_xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv, s, c;
    inv = 8'h00;
    c   = 8'h63;
    for (int y = 1; y < 256; y++)
      if (ref_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [127:0] ref_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {w3[23:0], w3[31:24]};
    t  = {ref_sbox(t[31:24]) ^ rc, ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])};
    n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  task automatic push_schedule(input logic [127:0] key);
    logic [127:0] k;
    logic [7:0]   rc;
    k = key; rc = 8'h01;
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) begin
        k  = ref_next(k, rc);
        rc = ref_xt(rc);
      end
      last_sched[r] = k;
      exp_q.push_back('{key: k, idx: 4'(r), dn: (r == 10)});
    end
  endtask

  task automatic start_schedule(input logic [127:0] key);
    @(negedge clk);
    start = 1'b1;
    cipher_key = key;
    push_schedule(key);
    @(negedge clk);
    start = 1'b0;
    cipher_key = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Stream monitor: every valid key must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && rk_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra idx=%0d rk=%h done=%b, no key expected", rk_idx, rk, done);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rk, rk_idx, done} !== {mon_e.key, mon_e.idx, mon_e.dn}) begin
          errors++;
          $display("FAIL stream_key got idx=%0d rk=%h done=%b want idx=%0d rk=%h done=%b",
                   rk_idx, rk, done, mon_e.idx, mon_e.key, mon_e.dn);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cipher_key = '0; rd_idx = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, rk_valid, done, rk_idx, rk, keys_ready, rd_key} !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%b vld=%b done=%b idx=%0d rk=%h rdy=%b rd=%h want all 0",
               busy, rk_valid, done, rk_idx, rk, keys_ready, rd_key);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_fips();
    int nb, nv;
    logic [127:0] g1, g10;
    logic gd;
    nb = 0; nv = 0; g1 = '0; g10 = '0; gd = 1'b0;
    start_schedule(K_FIPS);
    for (int c = 0; c < 13; c++) begin
      if (busy) nb++;
      if (rk_valid) begin
        nv++;
        if (rk_idx == 4'd1) g1 = rk;
        if (rk_idx == 4'd10) begin g10 = rk; gd = done; end
      end
      if (c < 12) @(negedge clk);
    end
    checks++;
    if (nb != 10) begin errors++; $display("FAIL fips_busy_cycles got %0d want 10", nb); end
    checks++;
    if (nv != 11) begin errors++; $display("FAIL fips_valid_cycles got %0d want 11", nv); end
    checks++;
    if (g1 !== RK1_FIPS) begin errors++; $display("FAIL fips_rk1 got %h want %h", g1, RK1_FIPS); end
    checks++;
    if (g10 !== RK10_FIPS) begin errors++; $display("FAIL fips_rk10 got %h want %h", g10, RK10_FIPS); end
    checks++;
    if (gd !== 1'b1) begin errors++; $display("FAIL fips_done got %b want 1", gd); end
    checks++;
    if (keys_ready !== STORE) begin errors++; $display("FAIL fips_keys_ready got %b want %b", keys_ready, STORE); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL fips_drain got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_store();
`ifdef AES_KEYSCHED_STORE_EN
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk); rd_idx = 4'(i);
      @(negedge clk);
      checks++;
      if (rd_key !== last_sched[i]) begin
        errors++; $display("FAIL store_read idx=%0d got %h want %h", i, rd_key, last_sched[i]);
      end
    end
    @(negedge clk); rd_idx = 4'd1;
    @(negedge clk);
    checks++;
    if (rd_key !== RK1_FIPS) begin errors++; $display("FAIL store_rk1 got %h want %h", rd_key, RK1_FIPS); end
    rd_idx = 4'd12;
    @(negedge clk);
    checks++;
    if (rd_key !== '0) begin errors++; $display("FAIL store_oob got %h want 0", rd_key); end
`else
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); rd_idx = 4'(i);
      @(negedge clk);
      checks++;
      if (rd_key !== '0 || keys_ready !== 1'b0) begin
        errors++; $display("FAIL nostore_read idx=%0d got rd=%h rdy=%b want 0/0", i, rd_key, keys_ready);
      end
    end
`endif
  endtask

  task automatic test_zero_key();
    logic [127:0] g10;
    bit seen;
    g10 = '0; seen = 1'b0;
    start_schedule('0);
    checks++;
    if (keys_ready !== 1'b0) begin errors++; $display("FAIL zero_ready_clear got %b want 0", keys_ready); end
    for (int c = 0; c < 15 && !seen; c++) begin
      if (rk_valid && rk_idx == 4'd10) begin
        seen = 1'b1; g10 = rk;
        checks++;
        if (keys_ready !== STORE) begin errors++; $display("FAIL zero_ready_set got %b want %b", keys_ready, STORE); end
      end else @(negedge clk);
    end
    checks++;
    if (!seen || g10 !== RK10_ZERO) begin
      errors++; $display("FAIL zero_rk10 got %h seen=%0d want %h", g10, seen, RK10_ZERO);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ks [0:2];
    int nv;
    nv = 0;
    for (int i = 0; i < 3; i++) ks[i] = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    for (int c = 0; c < 30; c++) begin
      start = 1'b1;
      if (c % 11 == 0) begin
        cipher_key = ks[c/11];
        push_schedule(ks[c/11]);
      end else begin
        cipher_key = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      if (rk_valid) nv++;
    end
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rk_valid) nv++;
    end
    checks++;
    if (nv != 33) begin errors++; $display("FAIL b2b_valid_cycles got %0d want 33", nv); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    int nv;
    seen = 1'b0; nv = 0;
    start_schedule({$urandom, $urandom, $urandom, $urandom});
    for (int c = 0; c < 20 && !seen; c++) begin
      if (rk_valid && rk_idx == 4'd5) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_mid_wait got no idx 5 want idx 5 within 20 cycles"); end
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, rk_valid, done, rk_idx, rk, keys_ready, rd_key} !== '0) begin
      errors++;
      $display("FAIL rst_mid_state busy=%b vld=%b done=%b idx=%0d rk=%h rdy=%b rd=%h want all 0",
               busy, rk_valid, done, rk_idx, rk, keys_ready, rd_key);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rk_valid || done || busy || keys_ready) nv++;
    end
    checks++;
    if (nv != 0) begin errors++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", nv); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fips();
    test_store();
    test_zero_key();
    test_back_to_back();
    test_reset_mid_run();
    test_fips();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_drain got %0d pending want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
